mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
Multi-cycle MIPS control FSM. It sequences fetch, decode, execute, memory and writeback for the supported subset, with one state per cycle and memory stalls where needed. It drives the 4-bit ALU selection code and all datapath strobes. It sits between the instruction register and memory interface on one side and the ALU, register file and PC muxes on the other.

Parameters:
ALU_SEL_W, 4, width of ALU selection code
OPC_W, 6, opcode and funct field width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
run  in  1  level; leave IDLE and start fetching
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write qualifier for mem_req
iord  out  1  0 = PC address, 1 = ALUOut address
ir_write  out  1  load IR
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if zero
pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sext imm<<2
alu_sel  out  4  ALU selection code
reg_write  out  1  register file write
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
illegal_op  out  1  one-cycle pulse on unsupported opcode/funct
state_o  out  4  current state encoding, for debug

Behaviour:
- Reset (reset_n = 0, async): state = IDLE; all outputs 0 (alu_sel = 0000, pc_source = 00, state_o = 0).
- Outputs are Moore: combinational decode of the state register only. The exception is alu_sel in EXECUTE, which also decodes funct.
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
- States and encodings:
  - IDLE (0): next FETCH if run, else IDLE.
  - FETCH (1): mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_sel = ADD. While mem_ready = 0, stay in FETCH with no other strobes. On mem_ready = 1, assert ir_write, pc_write (pc_source 00) and go to DECODE.
  - DECODE (2): alu_src_a = 0, alu_src_b = 11, alu_sel = ADD (branch target). Next state by opcode:
    - 0x00 → EXECUTE if funct ∈ {0x20, 0x22, 0x24, 0x25, 0x2A}
    - 0x23 or 0x2B → MEMADR
    - 0x04 → BRANCH
    - 0x08 → ADDIEX
    - 0x02 → JUMP
    - anything else → FETCH, with illegal_op = 1 in this cycle
  - MEMADR (3): alu_src_a = 1, alu_src_b = 10, ADD. Next MEMREAD for 0x23, MEMWRITE for 0x2B.
  - MEMREAD (4): mem_req = 1, iord = 1. Stay until mem_ready, then MEMWB.
  - MEMWB (5): reg_write = 1, reg_dst = 0, mem_to_reg = 1. Next FETCH.
  - MEMWRITE (6): mem_req = 1, mem_we = 1, iord = 1. Stay until mem_ready, then FETCH.
  - EXECUTE (7): alu_src_a = 1, alu_src_b = 00. alu_sel from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT. Next ALUWB.
  - ALUWB (8): reg_write = 1, reg_dst = 1, mem_to_reg = 0. Next FETCH.
  - BRANCH (9): alu_src_a = 1, alu_src_b = 00, SUB, pc_write_cond = 1, pc_source = 01. Next FETCH. The block does not gate by zero; the datapath does.
  - ADDIEX (10): alu_src_a = 1, alu_src_b = 10, ADD. Next ADDIWB.
  - ADDIWB (11): reg_write = 1, reg_dst = 0, mem_to_reg = 0. Next FETCH.
  - JUMP (12): pc_write = 1, pc_source = 10. Next FETCH.
- Handshake: once asserted, mem_req, mem_we and iord stay stable until the mem_ready cycle. mem_ready outside FETCH, MEMREAD or MEMWRITE is ignored.
- run is sampled only in IDLE. Deasserting run mid-instruction completes the instruction; the FSM never returns to IDLE except via reset.
- Unused encodings 13–15 go to FETCH next cycle with all outputs 0.
- Reset asserted mid-instruction, including during a memory stall, goes to IDLE immediately and drops mem_req asynchronously.
- Latency with mem_ready tied high:
  - R-type, addi, lw: 4, 4, 5 cycles
  - sw, beq, j: 4, 3, 3 cycles

Test Plan:
- Reset, run = 1, mem_ready = 1, R-type funct 0x22 → FETCH, DECODE, EXECUTE (alu_sel = 0110), ALUWB (reg_write = 1, reg_dst = 1), then FETCH; 4 cycles.
- lw 0x23 with mem_ready low for 3 cycles in MEMREAD → mem_req = 1 and iord = 1 held 4 cycles, then MEMWB with mem_to_reg = 1.
- opcode 0x3F → DECODE asserts illegal_op for exactly 1 cycle, next FETCH, reg_write never set.
- R-type funct 0x2A → alu_sel = 0111 in EXECUTE; funct 0x21 → illegal_op pulse, no EXECUTE.
- beq 0x04 → BRANCH with alu_sel = 0110, pc_write_cond = 1, pc_source = 01; j 0x02 → pc_write = 1, pc_source = 10; each 3 cycles.
- reset_n pulled low during FETCH stall (mem_ready = 0) → mem_req = 0 immediately, state_o = 0; run = 0 keeps the FSM in IDLE.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control
//
// Control FSM for a multi-cycle MIPS datapath. Each instruction runs through
// fetch, decode and one to three instruction-specific states, one state per
// cycle. Fetch, load and store hold a memory request until mem_ready.
//
// Supported instructions: R-type add/sub/and/or/slt, lw, sw, beq, addi, j.
// Any other opcode or funct pulses illegal_op in DECODE and returns to FETCH.
//
// Ports
//   clk, reset_n       rising-edge clock, asynchronous active-low reset
//   run                level; leaves IDLE and starts fetching (IDLE only)
//   opcode, funct      IR[31:26] / IR[5:0], valid from DECODE onward
//   zero               ALU zero flag (the datapath gates beq with it)
//   mem_ready          memory finishes the current request this cycle
//   mem_req/mem_we/iord         memory request, write qualifier, address mux
//   ir_write, pc_write, pc_write_cond, pc_source   IR and PC load control
//   alu_src_a, alu_src_b, alu_sel                  ALU operand and op select
//   reg_write, reg_dst, mem_to_reg                 register file write path
//   illegal_op         one-cycle pulse on an unsupported instruction
//   state_o            current state encoding, for debug
// ---------------------------------------------------------------------------
module mips_multicycle_control #(
    parameter int ALU_SEL_W = 4,
    parameter int OPC_W     = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic [OPC_W-1:0]     opcode,
    input  logic [OPC_W-1:0]     funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 iord,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic [1:0]           pc_source,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 illegal_op,
    output logic [3:0]           state_o
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDIEX   = 4'd10,
        S_ADDIWB   = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    localparam logic [ALU_SEL_W-1:0] ALU_AND = ALU_SEL_W'(4'b0000);
    localparam logic [ALU_SEL_W-1:0] ALU_OR  = ALU_SEL_W'(4'b0001);
    localparam logic [ALU_SEL_W-1:0] ALU_ADD = ALU_SEL_W'(4'b0010);
    localparam logic [ALU_SEL_W-1:0] ALU_SUB = ALU_SEL_W'(4'b0110);
    localparam logic [ALU_SEL_W-1:0] ALU_SLT = ALU_SEL_W'(4'b0111);

    localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'h00);
    localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'h23);
    localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'h2B);
    localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'h04);
    localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'h08);
    localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6'h02);

    localparam logic [OPC_W-1:0] FN_ADD = OPC_W'(6'h20);
    localparam logic [OPC_W-1:0] FN_SUB = OPC_W'(6'h22);
    localparam logic [OPC_W-1:0] FN_AND = OPC_W'(6'h24);
    localparam logic [OPC_W-1:0] FN_OR  = OPC_W'(6'h25);
    localparam logic [OPC_W-1:0] FN_SLT = OPC_W'(6'h2A);

    state_t state_q;
    state_t state_d;
    logic   funct_ok;

    // The branch decision is taken in the datapath (pc_write_cond & zero),
    // so the flag is intentionally not consumed here.
    logic unused_zero;
    assign unused_zero = zero;

    assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                      (funct == FN_OR)  || (funct == FN_SLT);

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value; a blocking '=' here would create order-dependent
    // simulation that no longer matches the synthesized flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output and state_d gets a default before the case, so
        // paths that do not mention a signal cannot infer a latch.
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_sel       = ALU_AND;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        illegal_op    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                // PC + 4 is computed every fetch cycle, but the PC and IR only
                // load in the cycle memory actually returns the instruction.
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                alu_sel   = ALU_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed speculatively into ALUOut.
                alu_src_b = 2'b11;
                alu_sel   = ALU_ADD;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct_ok) begin
                            state_d = S_EXECUTE;
                        end else begin
                            illegal_op = 1'b1;
                            state_d    = S_FETCH;
                        end
                    end
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_sel   = ALU_ADD;
                state_d   = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                case (funct)
                    FN_SUB:  alu_sel = ALU_SUB;
                    FN_AND:  alu_sel = ALU_AND;
                    FN_OR:   alu_sel = ALU_OR;
                    FN_SLT:  alu_sel = ALU_SLT;
                    default: alu_sel = ALU_ADD;
                endcase
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_sel       = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_d       = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_sel   = ALU_ADD;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = S_FETCH;
            end
            // Encodings 13-15: all outputs stay at their zero defaults and
            // the FSM recovers by fetching the next instruction.
            default: state_d = S_FETCH;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_control
//
// Self-checking bench. A reference model expands each instruction into its
// sequence of named phases and gives the full expected output vector of every
// cycle; random stalls, opcodes, funct, zero and run exercise the FSM.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_control;

    typedef struct packed {
        logic [3:0] state;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_sel;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal_op;
    } obs_t;

    logic       clk;
    logic       reset_n;
    logic       run;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_sel;
    logic       reg_write, reg_dst, mem_to_reg, illegal_op;
    logic [3:0] state_o;
    obs_t       act;

    int checks = 0;
    int errors = 0;

    mips_multicycle_control #(.ALU_SEL_W(4), .OPC_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_sel(alu_sel),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal_op(illegal_op), .state_o(state_o)
    );

    assign act = {state_o, mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
                  pc_source, alu_src_a, alu_src_b, alu_sel, reg_write, reg_dst,
                  mem_to_reg, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit funct_ok(input logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    endfunction

    function automatic logic [3:0] alu_code(input logic [5:0] fn);
        case (fn)
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h2A:   return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    // Expected outputs of one cycle spent in the named phase.
    function automatic obs_t phase_out(input string ph, input logic mr,
                                       input logic [5:0] fn, input bit ill);
        obs_t o;
        o = '0;
        case (ph)
            "FETCH":    begin o.state = 4'd1; o.mem_req = 1; o.alu_src_b = 2'b01;
                              o.alu_sel = 4'b0010; o.ir_write = mr; o.pc_write = mr; end
            "DECODE":   begin o.state = 4'd2; o.alu_src_b = 2'b11; o.alu_sel = 4'b0010;
                              o.illegal_op = ill; end
            "MEMADR":   begin o.state = 4'd3; o.alu_src_a = 1; o.alu_src_b = 2'b10;
                              o.alu_sel = 4'b0010; end
            "MEMREAD":  begin o.state = 4'd4; o.mem_req = 1; o.iord = 1; end
            "MEMWB":    begin o.state = 4'd5; o.reg_write = 1; o.mem_to_reg = 1; end
            "MEMWRITE": begin o.state = 4'd6; o.mem_req = 1; o.mem_we = 1; o.iord = 1; end
            "EXECUTE":  begin o.state = 4'd7; o.alu_src_a = 1; o.alu_sel = alu_code(fn); end
            "ALUWB":    begin o.state = 4'd8; o.reg_write = 1; o.reg_dst = 1; end
            "BRANCH":   begin o.state = 4'd9; o.alu_src_a = 1; o.alu_sel = 4'b0110;
                              o.pc_write_cond = 1; o.pc_source = 2'b01; end
            "ADDIEX":   begin o.state = 4'd10; o.alu_src_a = 1; o.alu_src_b = 2'b10;
                              o.alu_sel = 4'b0010; end
            "ADDIWB":   begin o.state = 4'd11; o.reg_write = 1; end
            "JUMP":     begin o.state = 4'd12; o.pc_write = 1; o.pc_source = 2'b10; end
            default:    o = '0;  // IDLE
        endcase
        return o;
    endfunction

    // One clock cycle: drive inputs on the falling edge, compare 1 ns later.
    task automatic step(input obs_t e, input logic mr, input logic [5:0] opc,
                        input logic [5:0] fn, input logic rn, input string name);
        @(negedge clk);
        mem_ready = mr;
        opcode    = opc;
        funct     = fn;
        run       = rn;
        zero      = 1'($urandom);
        #1;
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, e);
        end
    endtask

    // Expand one instruction into phases and check every cycle of it.
    task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn,
                             input int fstall, input int mstall, input string tag);
        string    plan[$];
        bit       ill;
        string    ph;
        int       nst;
        logic     mr;
        logic [5:0] d_opc, d_fn;
        ill = 0;
        plan.push_back("FETCH");
        plan.push_back("DECODE");
        case (opc)
            6'h00: if (funct_ok(fn)) begin plan.push_back("EXECUTE"); plan.push_back("ALUWB"); end
                   else ill = 1;
            6'h23: begin plan.push_back("MEMADR"); plan.push_back("MEMREAD"); plan.push_back("MEMWB"); end
            6'h2B: begin plan.push_back("MEMADR"); plan.push_back("MEMWRITE"); end
            6'h04: plan.push_back("BRANCH");
            6'h08: begin plan.push_back("ADDIEX"); plan.push_back("ADDIWB"); end
            6'h02: plan.push_back("JUMP");
            default: ill = 1;
        endcase
        foreach (plan[i]) begin
            ph = plan[i];
            // IR is not yet loaded during fetch, so the fields carry garbage.
            d_opc = (ph == "FETCH") ? 6'($urandom) : opc;
            d_fn  = (ph == "FETCH") ? 6'($urandom) : fn;
            if (ph == "FETCH" || ph == "MEMREAD" || ph == "MEMWRITE") begin
                nst = (ph == "FETCH") ? fstall : mstall;
                for (int k = 0; k < nst; k++)
                    step(phase_out(ph, 1'b0, fn, ill), 1'b0, d_opc, d_fn, 1'($urandom),
                         {tag, "/", ph, "_stall"});
                step(phase_out(ph, 1'b1, fn, ill), 1'b1, d_opc, d_fn, 1'($urandom),
                     {tag, "/", ph});
            end else begin
                mr = 1'($urandom);  // must be ignored outside memory phases
                step(phase_out(ph, mr, fn, ill), mr, d_opc, d_fn, 1'($urandom),
                     {tag, "/", ph});
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0; run = 1'b1; mem_ready = 1'b1;
        opcode = 6'h00; funct = 6'h20; zero = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
            checks++;
            if (act !== '0) begin
                errors++;
                $display("FAIL reset_outputs got %h exp %h", act, obs_t'('0));
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        run     = 1'b0;
    endtask

    task automatic test_run_low_idle(input int n, input string tag);
        for (int i = 0; i < n; i++)
            step(phase_out("IDLE", 1'b1, 6'h00, 0), 1'b1, 6'($urandom), 6'($urandom), 1'b0, tag);
    endtask

    task automatic test_start();
        // run seen in IDLE: this cycle is still IDLE, next is FETCH.
        step(phase_out("IDLE", 1'b1, 6'h00, 0), 1'b1, 6'h00, 6'h00, 1'b1, "start_idle");
    endtask

    task automatic test_rtype_sub();
        run_instr(6'h00, 6'h22, 0, 0, "rtype_sub");
    endtask

    task automatic test_lw_stall();
        run_instr(6'h23, 6'h15, 0, 3, "lw_stall");
    endtask

    task automatic test_illegal();
        run_instr(6'h3F, 6'h20, 0, 0, "illegal_3f");
    endtask

    task automatic test_slt_bad_funct();
        run_instr(6'h00, 6'h2A, 0, 0, "rtype_slt");
        run_instr(6'h00, 6'h21, 0, 0, "rtype_bad_funct");
    endtask

    task automatic test_branch_jump();
        run_instr(6'h04, 6'h00, 1, 0, "beq");
        run_instr(6'h02, 6'h00, 0, 0, "jump");
        run_instr(6'h2B, 6'h00, 2, 2, "sw_stall");
        run_instr(6'h08, 6'h00, 0, 0, "addi");
    endtask

    // Cycles from one FETCH to the next, measured on state_o, mem_ready high.
    task automatic measure(input logic [5:0] opc, input logic [5:0] fn,
                           input int exp_lat, input string tag);
        int cnt;
        @(negedge clk);
        mem_ready = 1'b1; opcode = opc; funct = fn; run = 1'b0;
        #1;
        checks++;
        if (state_o !== 4'd1) begin
            errors++;
            $display("FAIL %s_start state got %0d exp 1", tag, state_o);
        end
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            cnt++;
            if (state_o == 4'd1) break;
        end
        checks++;
        if (cnt != exp_lat) begin
            errors++;
            $display("FAIL %s_latency got %0d exp %0d", tag, cnt, exp_lat);
        end
    endtask

    task automatic test_latency();
        measure(6'h00, 6'h20, 4, "lat_rtype");
        measure(6'h08, 6'h00, 4, "lat_addi");
        measure(6'h23, 6'h00, 5, "lat_lw");
        measure(6'h2B, 6'h00, 4, "lat_sw");
        measure(6'h04, 6'h00, 3, "lat_beq");
        measure(6'h02, 6'h00, 3, "lat_j");
    endtask

    task automatic test_random(input int n);
        logic [5:0] opc, fn;
        logic [5:0] legal_fn [5];
        legal_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        for (int i = 0; i < n; i++) begin
            fn = 6'($urandom);
            case ($urandom_range(0, 7))
                0: begin opc = 6'h00; fn = legal_fn[$urandom_range(0, 4)]; end
                1: opc = 6'h00;
                2: opc = 6'h23;
                3: opc = 6'h2B;
                4: opc = 6'h04;
                5: opc = 6'h08;
                6: opc = 6'h02;
                default: opc = 6'($urandom);
            endcase
            run_instr(opc, fn, $urandom_range(0, 2), $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_reset_mid_stall();
        step(phase_out("FETCH", 1'b0, 6'h00, 0), 1'b0, 6'h11, 6'h11, 1'b1, "pre_reset_stall");
        #1;
        reset_n = 1'b0;
        run     = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_mem_req got %b exp 0", mem_req);
        end
        checks++;
        if (state_o !== 4'd0) begin
            errors++;
            $display("FAIL async_reset_state got %0d exp 0", state_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
        test_run_low_idle(4, "idle_run_low");
    endtask

    initial begin
        test_reset();
        test_run_low_idle(3, "idle_after_reset");
        test_start();
        test_rtype_sub();
        test_lw_stall();
        test_illegal();
        test_slt_bad_funct();
        test_branch_jump();
        test_latency();
        test_random(200);
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
